vmask_popc_acc: RTL and testbench
=================================

Name: vmask_popc_acc

Overview:
- Downstream consumer of the per-beat mask popcount stage, which emits a 4-bit count of set mask bits per 8-bit mask beat.
- Accumulates the partial counts across all beats of one vcpop.m instruction, from first beat to last beat, into a DATA_WIDTH scalar.
- Holds the finished scalar in an output register with a valid/ready handshake toward the scalar writeback path.
- Applies backpressure upstream only while an unconsumed result is held.

Parameters:
DATA_WIDTH, 64, width of accumulator and result scalar
CNT_WIDTH, 4, width of per-beat partial count input (max value 8)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (asserted at 0)
in_valid  input  1  partial-count beat valid
in_ready  output  1  block can accept a beat this cycle
in_first  input  1  beat is first of an instruction
in_last  input  1  beat is last of an instruction
in_pop  input  CNT_WIDTH  partial popcount of this beat
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  DATA_WIDTH  accumulated popcount
out_beats  output  DATA_WIDTH  number of beats accumulated into out_data

Behaviour:
- Reset (rst=0, async): state=IDLE, acc=0, beat_cnt=0, out_valid=0, out_data=0, out_beats=0, in_ready=1. Reset mid-instruction discards the partial sum with no output.
- Beat accepted ("fire") when in_valid && in_ready at posedge clk.
- States:
  - IDLE: no instruction open. Fire -> load acc=in_pop (zero-extended), beat_cnt=1. If in_last, go to DONE; else go to ACCUM. in_first is not required in IDLE; every beat accepted in IDLE starts a new instruction.
  - ACCUM: fire without in_first -> acc+=in_pop, beat_cnt+=1. Fire with in_first -> restart: acc=in_pop, beat_cnt=1, old partial discarded. Either case with in_last -> DONE.
  - DONE: out_valid=1. out_data and out_beats hold the completed acc and beat_cnt, stable until handshake.
- Result transfer:
  - On entering DONE, out_data and out_beats take the final sum and count in the same clock edge. out_valid is high the cycle after the last beat fires, giving 1-cycle latency.
  - out_valid && out_ready leaves DONE. Go to IDLE, or directly to ACCUM/DONE if a beat fires in the same cycle.
- in_ready = !(state==DONE) || out_ready. This is a combinational pass-through of out_ready in DONE, so back-to-back instructions run at full rate.
- Simultaneous result handshake and first-beat fire: the result is consumed and the new beat loads acc fresh, never added to the old sum.
- in_first && in_last on one beat: single-beat instruction, out_data=in_pop.
- Arithmetic:
  - acc and beat_cnt wrap modulo 2^DATA_WIDTH.
  - in_pop values above 8 are accumulated as given; no checking is done.
- in_valid=0 cycles inside ACCUM (bubbles) leave state unchanged.
- out_data and out_beats are don't-care when out_valid=0, but must be registered (no combinational path from in_pop).

Test Plan:
- Reset then single beat {first,last,pop=5}, out_ready=1 -> next cycle out_valid=1, out_data=5, out_beats=1; following cycle out_valid=0.
- Beats pop=8,8,3,0 (first on beat 0, last on beat 3), out_ready=1 -> one out_valid pulse with out_data=19, out_beats=4.
- out_ready=0 for 5 cycles after a result (data=7) with in_valid=1 held -> in_ready=0, out_data stays 7. Raise out_ready -> the same cycle accepts a new first beat pop=2; next result=2, not 9.
- Restart: first pop=4, then first pop=1, then last pop=1 -> out_data=2, out_beats=2.
- Bubbles: pop=3 (first), 2 idle cycles, pop=6 (last) -> out_data=9. Assert rst=0 asynchronously mid-instruction after pop=5 -> out_valid drops immediately. After release, {first,last,pop=1} gives out_data=1.
- Wrap: DATA_WIDTH=4, beats 8,8,1 -> out_data=1.

Source files
------------

// File: rtl/vmask_popc_acc.sv
// vmask_popc_acc: sums per-beat mask popcounts of one vcpop.m into a scalar,
// holding the result under a valid/ready handshake toward writeback.
module vmask_popc_acc #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [CNT_WIDTH-1:0]  in_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] out_beats
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, cnt_q, cnt_d, data_q, beats_q, pop_ext;
  logic valid_q, fire, fresh;
  assign in_ready  = (state_q != DONE) || out_ready;
  assign fire      = in_valid && in_ready;
  // Any beat taken outside ACCUM opens a new instruction, as does in_first.
  assign fresh     = (state_q != ACCUM) || in_first;
  assign pop_ext   = DATA_WIDTH'(in_pop);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_beats = beats_q;
  always_comb begin
    acc_d   = fresh ? pop_ext : acc_q + pop_ext;
    cnt_d   = fresh ? DATA_WIDTH'(1) : cnt_q + DATA_WIDTH'(1);
    state_d = fire ? (in_last ? DONE : ACCUM)
                   : ((state_q == DONE) && out_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= state_d == DONE;
      if (fire) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
      if (fire && in_last) begin
        data_q  <= acc_d;
        beats_q <= cnt_d;
      end
    end
  end
endmodule

// File: tb/tb_vmask_popc_acc.sv
// tb_vmask_popc_acc: directed plus random beats against an instruction-level
// popcount model; a 4-bit instance runs alongside to exercise wraparound.
module tb_vmask_popc_acc;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0] in_pop = '0;
  logic in_ready, out_valid, in_ready4, out_valid4;
  logic [63:0] out_data, out_beats;
  logic [3:0] out_data4, out_beats4;
  int total = 0, passed = 0;
  bit held = 0, open = 0;
  logic [63:0] sum = 0, cnt = 0, res = 0, resb = 0;

  always #5 clk = ~clk;

  vmask_popc_acc dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_pop(in_pop), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats));

  vmask_popc_acc #(.DATA_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready4), .in_first(in_first), .in_last(in_last), .in_pop(in_pop),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_beats(out_beats4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic compare();
    chk("in_ready", in_ready, !held || out_ready);
    chk("in_ready4", in_ready4, !held || out_ready);
    chk("out_valid", out_valid, held);
    chk("out_valid4", out_valid4, held);
    if (held) begin
      chk("out_data", out_data, res);
      chk("out_beats", out_beats, resb);
      chk("out_data4", out_data4, res & 64'hf);
      chk("out_beats4", out_beats4, resb & 64'hf);
    end
  endtask

  // Instruction-level model: a beat either continues the open instruction or
  // starts a new one; the last beat publishes the result.
  task automatic step(input logic v, f, l, input logic [3:0] p, input logic o);
    bit fire;
    in_valid = v; in_first = f; in_last = l; in_pop = p; out_ready = o;
    #1 compare();
    fire = v && (!held || o);
    @(posedge clk);
    if (held && o) held = 0;
    if (fire) begin
      if (!open || f) begin
        sum = 64'(p);
        cnt = 1;
      end else begin
        sum += 64'(p);
        cnt += 1;
      end
      open = !l;
      if (l) begin
        held = 1;
        res = sum;
        resb = cnt;
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    held = 0;
    open = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_beats", out_beats, 0);
    @(negedge clk) rst = 1'b1;
    step(1, 1, 1, 5, 1);
    chk("single_data", out_data, 5);
    chk("single_beats", out_beats, 1);
    step(0, 0, 0, 0, 1);
    chk("single_pulse_done", out_valid, 0);
    step(1, 1, 0, 8, 1);
    step(1, 0, 0, 8, 1);
    step(1, 0, 0, 3, 1);
    step(1, 0, 1, 0, 1);
    chk("multi_data", out_data, 19);
    chk("multi_beats", out_beats, 4);
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 7, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 2, 0);
    chk("hold_ready", in_ready, 0);
    chk("hold_data", out_data, 7);
    step(1, 1, 1, 2, 1);
    chk("no_merge_data", out_data, 2);
    step(1, 1, 0, 4, 1);
    step(1, 1, 0, 1, 1);
    step(1, 0, 1, 1, 1);
    chk("restart_data", out_data, 2);
    chk("restart_beats", out_beats, 2);
    step(1, 1, 0, 3, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 6, 1);
    chk("bubble_data", out_data, 9);
    step(1, 1, 1, 3, 0);
    #2 rst = 1'b0;
    #1 chk("async_valid_drop", out_valid, 0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    step(1, 1, 0, 5, 1);
    #2 rst = 1'b0;
    #1 chk("async_mid_valid", out_valid, 0);
    chk("async_mid_ready", in_ready, 1);
    model_reset();
    @(negedge clk) rst = 1'b1;
    step(1, 1, 1, 1, 1);
    chk("post_rst_data", out_data, 1);
    step(1, 1, 0, 8, 1);
    step(1, 0, 0, 8, 1);
    step(1, 0, 1, 1, 1);
    chk("wrap4_data", out_data4, 1);
    chk("wrap64_data", out_data, 17);
    step(1, 1, 1, 15, 1);
    chk("over8_data", out_data, 15);
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
           4'($urandom_range(15)), $urandom_range(3) != 0);
    step(0, 0, 0, 0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
